// File: rtl/chart_pkg.sv
// chart_pkg: shared definitions for the chart record/playback path.
//   - default field widths of a chart entry and of the chart RAM address
//   - chart_entry_t: packed {arrows, timing} RAM word
//   - TIME_TERM (end-of-chart marker) and GMAX (largest beat gap)
//   - recorder state encoding
package chart_pkg;
  localparam int CHART_ADDR_W  = 7;
  localparam int CHART_ARROW_W = 4;
  localparam int CHART_TIME_W  = 4;

  localparam logic [CHART_TIME_W-1:0] TIME_TERM = '0;
  localparam logic [CHART_TIME_W-1:0] GMAX      = '1;

  typedef struct packed {
    logic [CHART_ARROW_W-1:0] arrows;
    logic [CHART_TIME_W-1:0]  timing;
  } chart_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_REC,
    ST_DONE
  } rec_state_e;
endpackage

// File: rtl/chart_recorder_if.sv
// chart_recorder_if: chart RAM write port.
//   wr_valid  one-cycle write strobe
//   wr_addr   RAM word address
//   wr_data   packed {arrows, timing}
// master = recorder (drives), slave = RAM (receives).
interface chart_recorder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

// File: rtl/chart_recorder_edge_rise.sv
// edge_rise: per-bit rising-edge detector.
//   clk_i, reset_i  clock / synchronous active-high reset
//   d_i   [W]       level inputs (already synchronized)
//   rise_o[W]       high for the cycle in which a bit goes 0->1
module edge_rise #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] r_prev;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_prev <= '0;
    else         r_prev <= d_i;
  end

  assign rise_o = d_i & ~r_prev;
endmodule

// File: rtl/chart_recorder.sv
// chart_recorder: captures arrow presses, quantizes them to beat ticks and
// writes {arrows, timing} step entries into the chart RAM from address 0,
// closing the chart with a {0,0} terminator.
//   clk_i, reset_i  clock / synchronous active-high reset
//   beat_i          one-cycle beat tick
//   arrows_i        synchronized button levels
//   start_i/stop_i  begin / end a recording
//   wr              chart RAM write port (master)
//   recording_o     high while recording
//   full_o          recording ended because the RAM filled up
//   count_o         step entries written (terminator excluded)
// Optional: CHART_REC_CLEAR_EN zero-fills the whole RAM before recording.
module chart_recorder
  import chart_pkg::*;
#(
  parameter int ADDR_W  = CHART_ADDR_W,
  parameter int ARROW_W = CHART_ARROW_W,
  parameter int TIME_W  = CHART_TIME_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               beat_i,
  input  logic [ARROW_W-1:0] arrows_i,
  input  logic               start_i,
  input  logic               stop_i,
  chart_recorder_if.master   wr,
  output logic               recording_o,
  output logic               full_o,
  output logic [ADDR_W:0]    count_o
);
  localparam int                 DATA_W    = ARROW_W + TIME_W;
  localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;
  localparam logic [TIME_W-1:0]  T_MAX     = '1;

  rec_state_e          r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic [TIME_W-1:0]   r_g, w_g_nx, w_t;
  logic [ARROW_W-1:0]  r_pend, w_pend_nx, w_m, w_rise;
  logic                r_full, w_full_nx, r_rec;
  logic                r_wr_valid, w_wr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data, w_data;
  logic                w_clr, w_addr_inc, w_cnt_inc;

  edge_rise #(.W(ARROW_W)) u_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (arrows_i),
    .rise_o  (w_rise)
  );

  // A press landing on the beat cycle itself belongs to this beat.
  assign w_m = r_pend | w_rise;
  assign w_t = r_g + TIME_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_data     = '0;
    w_clr      = 1'b0;
    w_addr_inc = 1'b0;
    w_cnt_inc  = 1'b0;
    w_g_nx     = r_g;
    w_pend_nx  = r_pend;
    w_full_nx  = r_full;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_clr     = 1'b1;
          w_g_nx    = '0;
          w_pend_nx = '0;
          w_full_nx = 1'b0;
`ifdef CHART_REC_CLEAR_EN
          w_state_nx = ST_CLEAR;
`else
          w_state_nx = ST_REC;
`endif
        end
      end
`ifdef CHART_REC_CLEAR_EN
      ST_CLEAR: begin
        // Zero-fill; the address wraps back to 0 as REC begins.
        w_wr       = 1'b1;
        w_addr_inc = 1'b1;
        if (r_addr == ADDR_LAST) w_state_nx = ST_REC;
      end
`endif
      ST_REC: begin
        if (r_addr == ADDR_LAST || stop_i) begin
          // Last RAM word is reserved for the terminator; pending presses drop.
          w_wr       = 1'b1;
          w_state_nx = ST_DONE;
          w_pend_nx  = '0;
          if (r_addr == ADDR_LAST) w_full_nx = 1'b1;
        end else if (beat_i) begin
          if (w_m != '0) begin
            w_wr       = 1'b1;
            w_data     = {w_m, w_t};
            w_addr_inc = 1'b1;
            w_cnt_inc  = 1'b1;
            w_g_nx     = '0;
            w_pend_nx  = '0;
          end else if (w_t == T_MAX) begin
            // Rest entry keeps the gap representable in the timing field.
            w_wr       = 1'b1;
            w_data     = {{ARROW_W{1'b0}}, T_MAX};
            w_addr_inc = 1'b1;
            w_cnt_inc  = 1'b1;
            w_g_nx     = '0;
          end else begin
            w_g_nx = w_t;
          end
        end else begin
          w_pend_nx = w_m;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_g        <= '0;
      r_pend     <= '0;
      r_full     <= 1'b0;
      r_rec      <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_rec      <= (w_state_nx == ST_REC);
      r_g        <= w_g_nx;
      r_pend     <= w_pend_nx;
      r_full     <= w_full_nx;
      r_wr_valid <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_data;
      end
      if (w_clr) begin
        r_addr  <= '0;
        r_count <= '0;
      end else begin
        if (w_addr_inc) r_addr  <= r_addr + ADDR_W'(1);
        if (w_cnt_inc)  r_count <= r_count + (ADDR_W+1)'(1);
      end
    end
  end

  assign wr.wr_valid = r_wr_valid;
  assign wr.wr_addr  = r_wr_addr;
  assign wr.wr_data  = r_wr_data;
  assign recording_o = r_rec;
  assign full_o      = r_full;
  assign count_o     = r_count;
endmodule

// File: tb/tb_chart_recorder.sv
// Directed bench: a default chart_recorder (ADDR_W=7) and a small one
// (ADDR_W=3) share stimulus; outputs are sampled 1 time unit after posedge.
module tb_chart_recorder;
  import chart_pkg::*;

  logic       clk = 1'b0;
  logic       reset, beat, start, stop;
  logic [3:0] arrows;
  logic       rec, full, srec, sfull;
  logic [7:0] cnt;
  logic [3:0] scnt;
  int         n_err = 0;
  int         n_chk = 0;
  int         nw;
  logic [6:0] la;
  logic [7:0] ld;
  chart_entry_t ent;

  always #5 clk = ~clk;

  chart_recorder_if #(.ADDR_W(7), .DATA_W(8)) bif ();
  chart_recorder_if #(.ADDR_W(3), .DATA_W(8)) sif ();

  chart_recorder #(.ADDR_W(7)) u_dut (
    .clk_i(clk), .reset_i(reset), .beat_i(beat), .arrows_i(arrows),
    .start_i(start), .stop_i(stop), .wr(bif),
    .recording_o(rec), .full_o(full), .count_o(cnt)
  );

  chart_recorder #(.ADDR_W(3)) u_small (
    .clk_i(clk), .reset_i(reset), .beat_i(beat), .arrows_i(arrows),
    .start_i(start), .stop_i(stop), .wr(sif),
    .recording_o(srec), .full_o(sfull), .count_o(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pulse start and wait (bounded) for the big recorder to enter REC.
  task automatic do_start(input bit chk_clear);
    int ncl;
    ncl = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef CHART_REC_CLEAR_EN
    beat = 1'b1;  // beat inside CLEAR must not advance the gap
`endif
    for (int i = 0; i < 300 && !rec; i++) begin
      if (bif.wr_valid && bif.wr_data == 8'h00 && bif.wr_addr == 7'(ncl)) ncl++;
      tick();
      beat = 1'b0;
    end
    if (bif.wr_valid && bif.wr_data == 8'h00 && bif.wr_addr == 7'(ncl)) ncl++;
    beat = 1'b0;
    chk("rec_on", 32'(rec), 32'd1);
`ifdef CHART_REC_CLEAR_EN
    if (chk_clear) chk("clear_writes", 32'(ncl), 32'd128);
`else
    if (chk_clear) chk("no_clear_writes", 32'(ncl), 32'd0);
`endif
    tick();
  endtask

  initial begin
    reset = 1'b0; beat = 1'b0; start = 1'b0; stop = 1'b0; arrows = 4'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bif.wr_valid), 32'd0);
    chk("rst_addr",  32'(bif.wr_addr),  32'd0);
    chk("rst_data",  32'(bif.wr_data),  32'd0);
    chk("rst_rec",   32'(rec),          32'd0);
    chk("rst_full",  32'(full),         32'd0);
    chk("rst_cnt",   32'(cnt),          32'd0);
    chk("rst_scnt",  32'(scnt),         32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("idle_stop_ignored", 32'(bif.wr_valid), 32'd0);

    // Press 0001 between beats 2 and 3 -> {0001, 3}
    do_start(1'b1);
    for (int i = 0; i < 2; i++) begin
      beat = 1'b1; tick(); beat = 1'b0;
      chk("gap_no_write", 32'(bif.wr_valid), 32'd0);
      tick();
    end
    arrows = 4'b0001; tick();
    beat = 1'b1; tick(); beat = 1'b0;
    chk("a_valid", 32'(bif.wr_valid), 32'd1);
    chk("a_addr",  32'(bif.wr_addr),  32'd0);
    chk("a_data",  32'(bif.wr_data),  32'h13);
    chk("a_cnt",   32'(cnt),          32'd1);
    arrows = 4'b0; tick();
    chk("a_pulse", 32'(bif.wr_valid), 32'd0);

    // 0100 in the interval plus 0010 on the beat cycle -> {0110, 1}
    arrows = 4'b0100; tick();
    arrows = 4'b0000; tick();
    beat = 1'b1; arrows = 4'b0010; tick();
    beat = 1'b0; arrows = 4'b0000;
    ent.arrows = 4'b0110; ent.timing = 4'd1;
    chk("b_valid", 32'(bif.wr_valid), 32'd1);
    chk("b_addr",  32'(bif.wr_addr),  32'd1);
    chk("b_data",  32'(bif.wr_data),  32'(ent));
    chk("b_cnt",   32'(cnt),          32'd2);
    tick();

    // 15 idle beats -> one rest entry; 31 more -> two rest entries
    nw = 0; la = '0; ld = '0;
    for (int i = 0; i < 15; i++) begin
      beat = 1'b1; tick(); beat = 1'b0;
      if (bif.wr_valid) begin nw++; la = bif.wr_addr; ld = bif.wr_data; end
      tick();
    end
    chk("r15_nw",   32'(nw),  32'd1);
    chk("r15_addr", 32'(la),  32'd2);
    chk("r15_data", 32'(ld),  32'h0F);
    chk("r15_cnt",  32'(cnt), 32'd3);
    nw = 0;
    for (int i = 0; i < 31; i++) begin
      beat = 1'b1; tick(); beat = 1'b0;
      if (bif.wr_valid) begin nw++; la = bif.wr_addr; ld = bif.wr_data; end
      tick();
    end
    chk("r31_nw",   32'(nw),  32'd2);
    chk("r31_addr", 32'(la),  32'd4);
    chk("r31_data", 32'(ld),  32'h0F);
    chk("r31_cnt",  32'(cnt), 32'd5);

    // stop with a same-cycle beat and a pending press -> terminator only
    arrows = 4'b1000; tick();
    arrows = 4'b0000; tick();
    beat = 1'b1; stop = 1'b1; tick();
    beat = 1'b0; stop = 1'b0;
    chk("s_valid", 32'(bif.wr_valid), 32'd1);
    chk("s_addr",  32'(bif.wr_addr),  32'd5);
    chk("s_data",  32'(bif.wr_data),  32'h00);
    chk("s_cnt",   32'(cnt),          32'd5);
    chk("s_rec",   32'(rec),          32'd0);
    chk("s_full",  32'(full),         32'd0);
    tick();
    beat = 1'b1; arrows = 4'b0001; tick(); beat = 1'b0; arrows = 4'b0;
    chk("done_no_write", 32'(bif.wr_valid), 32'd0);
    chk("done_cnt_hold", 32'(cnt),          32'd5);
    tick();

    // Capacity on the ADDR_W=3 recorder: press on every beat
    do_reset();
    do_start(1'b0);
    for (int i = 0; i < 7; i++) begin
      beat = 1'b1; arrows = 4'b0001; tick();
      beat = 1'b0; arrows = 4'b0000;
      chk("f_valid", 32'(sif.wr_valid), 32'd1);
      chk("f_addr",  32'(sif.wr_addr),  32'(i));
      chk("f_data",  32'(sif.wr_data),  32'h11);
      tick();
    end
    chk("f_term_valid", 32'(sif.wr_valid), 32'd1);
    chk("f_term_addr",  32'(sif.wr_addr),  32'd7);
    chk("f_term_data",  32'(sif.wr_data),  32'h00);
    chk("f_full",       32'(sfull),        32'd1);
    chk("f_cnt",        32'(scnt),         32'd7);
    chk("f_rec",        32'(srec),         32'd0);
    beat = 1'b1; arrows = 4'b0001; tick(); beat = 1'b0; arrows = 4'b0;
    chk("f_after_no_write", 32'(sif.wr_valid), 32'd0);
    chk("f_after_cnt",      32'(scnt),         32'd7);
    chk("big_not_full",     32'(full),         32'd0);
    chk("big_cnt",          32'(cnt),          32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/chart_recorder.md
Name: chart_recorder

Overview:
- Writer-side counterpart to the chart playback path. Captures player arrow presses in real time.
- Quantizes presses to beat ticks and writes packed {arrows, timing} step entries into the chart's ram_1r1w_sync through its write port.
- Playback later reads these entries back sequentially from address 0.
- Sits between the synchronized button inputs / beat generator and the chart RAM write port.

Parameters:
- ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W entries.
- ARROW_W, 4, arrow mask width (upper field of each entry).
- TIME_W, 4, timing field width (lower field); max gap GMAX = 2**TIME_W-1 = 15.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- beat_i  in  1  one-cycle beat tick.
- arrows_i  in  ARROW_W  button levels, already synchronized to clk_i.
- start_i  in  1  begin recording at address 0.
- stop_i  in  1  end recording.
- wr_valid_o  out  1  RAM write strobe.
- wr_addr_o  out  ADDR_W  RAM write address.
- wr_data_o  out  ARROW_W+TIME_W  {arrows, timing}.
- recording_o  out  1  high in REC.
- full_o  out  1  recording ended on capacity.
- count_o  out  ADDR_W+1  entries written, excluding terminator.

Behaviour:
- Single clock domain; synchronous active-high reset.
- Reset values: all outputs 0; state IDLE; internal addr, gap g, pending mask and prev-arrows register all 0.
- All outputs are registered. A write appears one cycle after its causing event.
- Edge detect:
  - rise = arrows_i & ~prev; prev <= arrows_i every cycle.
  - In REC, pending <= pending | rise.
- States and transitions:
  - IDLE: start_i -> REC. Clears addr, g, pending, count_o, full_o.
  - REC, on beat_i: let m = pending | rise (same-cycle edges count) and t = g+1.
    - m != 0: write {m, t} at addr; addr++, count++, g <= 0, pending <= 0.
    - m == 0 and t == GMAX: write rest entry {0, GMAX}; addr++, count++, g <= 0.
    - Otherwise g <= t.
  - REC, without beat_i: no write; pending keeps accumulating.
  - REC, stop_i: write terminator {0,0} at addr -> DONE. Pending presses are discarded.
  - stop_i has priority over a same-cycle beat_i.
  - Capacity: after a write to addr DEPTH-2, the next cycle writes the terminator at DEPTH-1, sets full_o=1 -> DONE. Any beat in that cycle is ignored.
  - DONE: outputs hold (count_o, full_o). start_i -> REC with the same clears as IDLE.
  - start_i while in REC is ignored. stop_i in IDLE/DONE is ignored.
- Timing field invariants:
  - Always in 1..GMAX for step entries.
  - 0 marks the terminator only; playback treats timing 0 as end-of-chart.
  - At most one write per cycle. wr_valid_o is a single-cycle pulse per entry.
- Reset mid-recording aborts immediately. RAM contents are not cleared; the previous terminator may be absent.
- count_o max = DEPTH-1 (127 at default).

Optional Feature:
- Macro: CHART_REC_CLEAR_EN.
- Defined: start_i enters state CLEAR first.
  - Writes {0,0} to addr 0..DEPTH-1, one per cycle (DEPTH cycles), recording_o=0.
  - Then enters REC with addr=0.
  - beat_i and stop_i are ignored during CLEAR. Arrow edges are not accumulated.
- Not defined: no CLEAR state; start_i goes directly to REC. Stale entries beyond the terminator remain.

Decomposition:
- Shared package chart_pkg holds:
  - ARROW_W, TIME_W, ADDR_W defaults.
  - typedef chart_entry_t (packed struct arrows, timing).
  - TIME_TERM = 0, GMAX.
  - State enum {IDLE, CLEAR, REC, DONE}.
- One natural sub-module: edge_rise (per-bit rising-edge detector with prev register), parameterized by width.
- Address and count use the existing counter_up style with up-enable.

Test Plan:
- Reset, then start; press arrow 4'b0001 between beats 2 and 3 -> single write addr 0 data 8'h13; count_o=1.
- Press 4'b0100 and 4'b0010 in the same beat interval -> one write {4'b0110, t}; same-cycle edge with beat_i is included.
- No presses for 15 beats -> rest entry 8'h0F at the next addr, g restarts. 31 idle beats -> two 8'h0F entries.
- stop_i coincident with beat_i and a pending press -> only terminator 8'h00 written; DONE; recording_o=0.
- Press every beat with ADDR_W=3 -> entries at addr 0..6, terminator at 7, full_o=1, count_o=7, later beats produce no writes.
- CHART_REC_CLEAR_EN defined, start_i -> 128 consecutive zero writes addr 0..127, then REC; a beat during CLEAR produces no entry.
